icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the fetch stage's instruction bus (`ibus_req_t`/`ibus_resp_t`) and the memory-side cache bus (`cbus_req_t`/`cbus_resp_t`). Hits return one cycle after acceptance. Misses refill a whole line with an incrementing burst. Addresses below `0x8000_0000` bypass the cache as single-beat uncached reads. A `flush` pulse, driven by `FENCE.I`, invalidates every line.

## Interface
- `NUM_LINES`, default 64: number of lines; power of two.
- `LINE_WORDS`, default 4: 64-bit words per line; power of two, 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, **synchronous and active-low**: reset is applied when `rst == 0` at a rising edge.
- `ireq`  in  `ibus_req_t`  `valid`, `addr[63:0]` from fetch; `addr` is held stable until `data_ok`.
- `iresp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data[31:0]`.
- `flush`  in  1  one-cycle invalidate-all request.
- `creq`  out  `cbus_req_t`  `valid`, `is_write` = 0, `size` = MSIZE8, `addr`, `len`, `burst`, `strobe` = 0, `data` = 0.
- `cresp`  in  `cbus_resp_t`  `ready`, `last`, `data[63:0]`.

## Operation
**Address split**
- offset = `addr[OFS-1:0]`, where OFS = log2(`LINE_WORDS`·8).
- index = next log2(`NUM_LINES`) bits.
- tag = remaining upper bits.
- word select = `addr[OFS-1:3]`.
- The returned instruction is `word[63:32]` when `addr[2]` = 1, else `word[31:0]`.

**Storage**
- Per-line `valid` bit and tag.
- Data array of `NUM_LINES`×`LINE_WORDS`×64 bits.
- Latched request address `raddr`.

**FSM**
- **IDLE**
  - `addr_ok` = `ireq.valid`.
  - On accept, latch `raddr`.
  - If `raddr[31]` = 0, go to UNCACHED; otherwise go to COMPARE.
- **COMPARE**
  - Hit (`valid[idx]` and tag match): `data_ok` = 1 with the selected instruction, then go to IDLE.
  - Miss: go to REFILL.
- **REFILL**
  - `creq.valid` = 1, `addr` = `raddr` line-aligned, `len` = `LINE_WORDS`−1, `burst` = INCR.
  - Beat counter starts at 0. Each `cresp.ready` writes `data[idx][cnt]` and increments the counter.
  - On `ready & last`, write the tag, set `valid[idx]` (unless a flush is pending), and go to RESPOND.
- **RESPOND**
  - `data_ok` = 1 with the instruction read from the array at `raddr`, then go to IDLE.
- **UNCACHED**
  - `creq.valid` = 1, `addr` = `raddr` & ~7, `len` = 0, `burst` = FIXED.
  - On `ready`, capture the beat into `ubuf` and go to UBACK.
- **UBACK**
  - `data_ok` = 1, instruction selected from `ubuf` by `raddr[2]`.
  - No array update. Go to IDLE.

**Flush**
- Sampled in every state; clears all `valid` bits at that edge.
- In REFILL, it additionally sets `flush_pending`. The line being refilled is written but left invalid. RESPOND still returns the fetched data.
- `flush_pending` clears on return to IDLE.

**Reset**
- Reset in any state, including mid-burst: go to IDLE, clear all `valid` bits, beat counter, and `flush_pending`.
- `creq.valid` drops in the same cycle reset is sampled. The memory side is reset together with this block, so an abandoned burst is not resumed.

## Timing
- Reset values: `iresp` = 0 (`addr_ok`, `data_ok`, `data`), `creq.valid` = 0, FSM state IDLE.
- Hit: accept at cycle t, `data_ok` at t+1, next accept possible at t+2.
- Miss: REFILL starts at t+2; RESPOND follows the cycle after the `last` beat.
- Uncached: `data_ok` the cycle after `ready`.
- `data_ok` is a one-cycle pulse.
- `creq` fields are constant while `creq.valid` is high.
- Back-pressure: a `ready` = 0 cycle holds the state and the beat counter.

## Structure
- `ibus_*`, `cbus_*`, `MSIZE8`, and the INCR/FIXED burst encodings already live in package `common`. The FSM state enum `icache_state_t` is added there.
- One sub-module, `icache_data`: the data array with one synchronous write port (index, word, data) and two combinational read ports (hit path and RESPOND path). Tag and valid storage stay in `icache`.

## Test plan
- **Cold miss then hit.** Request `0x8000_0004`; memory returns beats `0x…1111_2222_3333_4444`, then 3 more. Expect a 4-beat burst at `0x8000_0000`, `len` = 3, and `data_ok` with `0x1111_2222`. Re-request `0x8000_0000`: `data_ok` exactly 1 cycle after accept, `data` = `0x3333_4444`, `creq.valid` stays 0.
- **Conflict eviction.** Fill `0x8000_0000`, then request `0x8000_0800`, which has the same index. Expect a refill. A re-request of `0x8000_0000` misses again.
- **Uncached.** Request `0x0000_1004`; memory returns `0xDEAD_BEEF_0000_0013`. Expect `len` = 0, addr `0x1000`, `data` = `0xDEAD_BEEF`, then a repeat request refetches.
- **Back-pressure.** During a refill, hold `ready` low for 3 cycles between beats 1 and 2. All 4 words must be stored in order, and the next hit returns word 2 correctly.
- **Flush during refill.** Pulse `flush` on beat 2. `data_ok` still returns the correct instruction. An immediate re-request of the same address must miss, and earlier valid lines must miss too.
- **Reset mid-burst.** Drive `rst` = 0 after beat 1. The next cycle shows `creq.valid` = 0 and state IDLE. After release, a request to the same line performs a full 4-beat refill.

Source files
------------

// File: rtl/common_pkg.sv
// Shared bus types for the fetch-side and memory-side cache buses, plus the
// instruction cache FSM state and a small instruction-select helper.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01
  } burst_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  len;
    burst_t      burst;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    REFILL   = 3'd2,
    RESPOND  = 3'd3,
    UNCACHED = 3'd4,
    UBACK    = 3'd5
  } icache_state_t;

  // Pick the 32-bit instruction out of a 64-bit word using address bit 2.
  function automatic logic [31:0] sel_inst(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/icache_data.sv
// Instruction cache data array: one synchronous write port used by refill,
// two combinational read ports (hit path and refill-response path).
module icache_data
  import common::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(NUM_LINES)-1:0]  widx,
  input  logic [$clog2(LINE_WORDS)-1:0] wword,
  input  logic [63:0]                   wdata,
  input  logic [$clog2(NUM_LINES)-1:0]  ridx_a,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_a,
  output logic [63:0]                   rdata_a,
  input  logic [$clog2(NUM_LINES)-1:0]  ridx_b,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_b,
  output logic [63:0]                   rdata_b
);

  logic [63:0] mem [NUM_LINES*LINE_WORDS];

  // Refill beats land here, addressed as {line index, word in line}.
  always_ff @(posedge clk) begin
    if (we) mem[{widx, wword}] <= wdata;
  end

  assign rdata_a = mem[{ridx_a, rword_a}];
  assign rdata_b = mem[{ridx_b, rword_b}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Cacheable lines (addr[31]=1)
// refill with an INCR burst; lower addresses go out as single FIXED beats.
module icache
  import common::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  logic       flush,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int OFS    = $clog2(LINE_WORDS * 8);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = 64 - OFS - IDX_W;

  icache_state_t state, state_next;

  logic [63:0]          raddr;
  logic [63:0]          ubuf;
  logic [NUM_LINES-1:0] valid_bits;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [WSEL_W-1:0]    cnt;
  logic                 flush_pending;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              hit;
  logic              accept;
  logic              beat;
  logic              fill_done;
  logic [63:0]       rdata_hit;
  logic [63:0]       rdata_resp;
  logic              unused_bits;

  assign idx  = raddr[OFS +: IDX_W];
  assign tag  = raddr[63 -: TAG_W];
  assign wsel = raddr[OFS-1:3];
  assign hit  = valid_bits[idx] && (tags[idx] == tag);

  // Accept only out of reset so nothing is latched while rst is low.
  assign accept    = rst && (state == IDLE) && ireq.valid;
  assign beat      = rst && (state == REFILL) && cresp.ready;
  assign fill_done = beat && cresp.last;

  assign unused_bits = ^raddr[1:0];

  icache_data #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_data (
    .clk    (clk),
    .we     (beat),
    .widx   (idx),
    .wword  (cnt),
    .wdata  (cresp.data),
    .ridx_a (idx),
    .rword_a(wsel),
    .rdata_a(rdata_hit),
    .ridx_b (idx),
    .rword_b(wsel),
    .rdata_b(rdata_resp)
  );

  // FSM state register; reset always returns to IDLE, abandoning any burst.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and bus outputs, all derived from the current state.
  always_comb begin
    state_next    = state;
    iresp         = '0;
    creq          = '0;
    creq.size     = MSIZE8;
    creq.burst    = BURST_FIXED;
    unique case (state)
      IDLE: begin
        iresp.addr_ok = ireq.valid && rst;
        if (ireq.valid) state_next = ireq.addr[31] ? COMPARE : UNCACHED;
      end
      COMPARE: begin
        if (hit) begin
          iresp.data_ok = 1'b1;
          iresp.data    = sel_inst(rdata_hit, raddr[2]);
          state_next    = IDLE;
        end else begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        creq.valid = 1'b1;
        creq.addr  = {raddr[63:OFS], {OFS{1'b0}}};
        creq.len   = 8'(LINE_WORDS - 1);
        creq.burst = BURST_INCR;
        if (fill_done) state_next = RESPOND;
      end
      RESPOND: begin
        iresp.data_ok = 1'b1;
        iresp.data    = sel_inst(rdata_resp, raddr[2]);
        state_next    = IDLE;
      end
      UNCACHED: begin
        creq.valid = 1'b1;
        creq.addr  = {raddr[63:3], 3'b000};
        creq.len   = 8'd0;
        if (cresp.ready) state_next = UBACK;
      end
      UBACK: begin
        iresp.data_ok = 1'b1;
        iresp.data    = sel_inst(ubuf, raddr[2]);
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request address latch and uncached beat buffer (datapath, not reset).
  always_ff @(posedge clk) begin
    if (accept) raddr <= ireq.addr;
    if (state == UNCACHED && cresp.ready) ubuf <= cresp.data;
  end

  // Refill beat counter and the flush-during-refill marker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (beat) cnt <= cnt + WSEL_W'(1);
      if (state == IDLE) begin
        cnt           <= '0;
        flush_pending <= 1'b0;
      end
      if (flush && state == REFILL) flush_pending <= 1'b1;
    end
  end

  // Line valid bits: flush wins, a refill completed under flush stays invalid.
  always_ff @(posedge clk) begin
    if (!rst)                                valid_bits      <= '0;
    else if (flush)                          valid_bits      <= '0;
    else if (fill_done && !flush_pending)    valid_bits[idx] <= 1'b1;
  end

  // Tag store, written when the last refill beat arrives.
  always_ff @(posedge clk) begin
    if (fill_done) tags[idx] <= tag;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a scoreboard of expected instructions,
// a behavioural memory slave with optional stall, flush and reset injection.
module tb_icache;
  import common::*;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       flush;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  icache #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .ireq (ireq),
    .iresp(iresp),
    .flush(flush),
    .creq (creq),
    .cresp(cresp)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // memory-side bookkeeping
  int          bursts = 0;
  int          hs_count = 0;
  logic [63:0] last_baddr = '0;
  logic [7:0]  last_blen = '0;
  logic [1:0]  last_bburst = '0;
  int          stall_at = -1;
  int          stall_n = 0;
  int          flush_at = -1;
  int          m_beat = 0;
  int          m_stall = 0;
  logic        m_active = 1'b0;
  logic [63:0] m_base = '0;
  logic [7:0]  m_len = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1111_2222_3333_4444;
    if (a == 64'h0000_1000) return 64'hDEAD_BEEF_0000_0013;
    return {a[31:0] ^ 32'hC0DE_0000, a[31:0] + 32'h0101_0101};
  endfunction

  function automatic logic [31:0] model_inst(input logic [63:0] a);
    logic [63:0] w;
    w = mem_rd({a[63:3], 3'b000});
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  always @(posedge clk) begin
    if (rst && creq.valid && cresp.ready) hs_count <= hs_count + 1;
  end

  // Memory slave: decides at each falling edge what to offer at the next rise.
  initial begin
    cresp = '0;
    flush = 1'b0;
    forever begin
      @(negedge clk);
      if (cresp.ready) begin
        m_beat++;
        if (cresp.last) m_active = 1'b0;
        if (m_beat == stall_at) m_stall = stall_n;
      end
      cresp = '0;
      flush = 1'b0;
      if (!creq.valid || !rst) m_active = 1'b0;
      if (creq.valid && rst) begin
        if (!m_active) begin
          m_active    = 1'b1;
          m_beat      = 0;
          m_stall     = 0;
          m_base      = creq.addr;
          m_len       = creq.len;
          bursts++;
          last_baddr  = creq.addr;
          last_blen   = creq.len;
          last_bburst = creq.burst;
          chk("creq_is_write", creq.is_write, 0);
          chk("creq_size", creq.size, MSIZE8);
        end else begin
          chk("creq_addr_stable", creq.addr, m_base);
          chk("creq_len_stable", creq.len, m_len);
        end
        if (m_stall > 0) begin
          m_stall--;
        end else begin
          cresp.ready = 1'b1;
          cresp.data  = mem_rd(m_base + 64'(m_beat) * 64'd8);
          cresp.last  = (m_beat == int'(m_len));
          if (m_beat == flush_at) flush = 1'b1;
        end
      end
    end
  end

  // One fetch: push the model's instruction, wait for data_ok, pop and compare.
  task automatic fetch(input logic [63:0] a, output int lat, output int nb, output int nbeats);
    int b0, h0, n;
    logic got;
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = a;
    exp_q.push_back(model_inst(a));
    b0 = bursts;
    h0 = hs_count;
    #1;
    n = 0;
    while (!iresp.addr_ok && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!iresp.addr_ok) chk("addr_ok_timeout", 0, 1);
    @(negedge clk);
    ireq.valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (lat < 200) begin
      if (iresp.data_ok) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (got) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
      else chk("data", iresp.data, exp_q.pop_front());
      @(negedge clk);
      chk("data_ok_pulse", iresp.data_ok, 0);
    end else begin
      chk("data_ok_timeout", 0, 1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    nb     = bursts - b0;
    nbeats = hs_count - h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, nbeats, h0, n;
    logic [63:0] ra;

    rst  = 1'b0;
    ireq = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr_ok", iresp.addr_ok, 0);
    chk("rst_data_ok", iresp.data_ok, 0);
    chk("rst_data", iresp.data, 0);
    chk("rst_creq_valid", creq.valid, 0);
    chk("rst_state", dut.state, IDLE);
    rst = 1'b1;

    // cold miss then hit
    fetch(64'h8000_0004, lat, nb, nbeats);
    chk("cold_bursts", nb, 1);
    chk("cold_beats", nbeats, 4);
    chk("cold_addr", last_baddr, 64'h8000_0000);
    chk("cold_len", last_blen, 3);
    chk("cold_burst", last_bburst, BURST_INCR);
    fetch(64'h8000_0000, lat, nb, nbeats);
    chk("hit_latency", lat, 1);
    chk("hit_bursts", nb, 0);

    // conflict eviction
    fetch(64'h8000_0800, lat, nb, nbeats);
    chk("conflict_bursts", nb, 1);
    fetch(64'h8000_0000, lat, nb, nbeats);
    chk("evicted_bursts", nb, 1);

    // uncached
    fetch(64'h0000_1004, lat, nb, nbeats);
    chk("unc_bursts", nb, 1);
    chk("unc_beats", nbeats, 1);
    chk("unc_addr", last_baddr, 64'h0000_1000);
    chk("unc_len", last_blen, 0);
    chk("unc_burst", last_bburst, BURST_FIXED);
    fetch(64'h0000_1004, lat, nb, nbeats);
    chk("unc_refetch", nb, 1);

    // back-pressure between beats 1 and 2
    stall_at = 2;
    stall_n  = 3;
    fetch(64'h8000_1040, lat, nb, nbeats);
    stall_at = -1;
    chk("bp_beats", nbeats, 4);
    fetch(64'h8000_1050, lat, nb, nbeats);
    chk("bp_hit_w2", nb, 0);
    fetch(64'h8000_1044, lat, nb, nbeats);
    fetch(64'h8000_105C, lat, nb, nbeats);
    chk("bp_hit_w3", lat, 1);

    // flush on beat 2 of a refill
    flush_at = 2;
    fetch(64'h8000_20C4, lat, nb, nbeats);
    flush_at = -1;
    chk("flush_fill_bursts", nb, 1);
    fetch(64'h8000_20C4, lat, nb, nbeats);
    chk("flush_same_miss", nb, 1);
    fetch(64'h8000_1040, lat, nb, nbeats);
    chk("flush_old_miss", nb, 1);

    // reset after beat 1 of a burst
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_3000;
    h0 = hs_count;
    @(negedge clk);
    ireq.valid = 1'b0;
    n = 0;
    while (hs_count - h0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_beats", hs_count - h0, 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_creq_valid", creq.valid, 0);
    chk("rstmid_state", dut.state, IDLE);
    chk("rstmid_data_ok", iresp.data_ok, 0);
    @(negedge clk);
    rst = 1'b1;
    fetch(64'h8000_3008, lat, nb, nbeats);
    chk("rstmid_refill_bursts", nb, 1);
    chk("rstmid_refill_beats", nbeats, 4);

    // random cacheable fetches, each immediately repeated as a hit
    for (int i = 0; i < 8; i++) begin
      ra = 64'h8000_0000 + 64'($urandom_range(0, 16'h3FFF) & 32'hFFFF_FFFC);
      fetch(ra, lat, nb, nbeats);
      fetch(ra, lat, nb, nbeats);
      chk("rand_hit_latency", lat, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
